// File: rtl/ccx2max_stream.sv
// ccx2max_stream: bridge between one OpenSPARC core's PCX/CPX ports and a pair of
// Maxeler streams with a parametrised beat width.
//   Outbound: PCX requests are buffered (PCX_DEPTH entries) and serialised into
//   PCX_BEATS-beat frames {atom, req, data}, LSB slice first, sof on beat 0.
//   Inbound: framed beats are assembled into CPX packets and delivered as a
//   one-cycle cpx_spc_data_rdy_cx2 pulse.
// Configuration macro: CCX2MAX_CPX_RESYNC_EN enables realignment of the inbound
//   assembler on max_cpx_sof; when undefined, sof is ignored and framing is by
//   beat count alone (cpx_resync stays 0).
// Ports:
//   gclk, reset                      clock, asynchronous active-high reset
//   core_reset_done                  gates inbound reads
//   spc_pcx_req_pq/atom_pq/data_pa   PCX request, atomic flag, packet (next cycle)
//   pcx_spc_grant_px                 grant pulse with the sent entry's req bits
//   max_pcx_valid/data/sof/stall     outbound beat stream
//   max_cpx_empty/data/sof/read      inbound FWFT beat stream
//   cpx_spc_data_rdy_cx2/data_cx2    CPX packet to the core
//   pcx_overflow, cpx_resync         sticky status flags
module ccx2max_stream #(
  parameter int unsigned MAX_D_WIDTH = 32,
  parameter int unsigned PCX_WIDTH   = 124,
  parameter int unsigned CPX_WIDTH   = 145,
  parameter int unsigned PCX_DEPTH   = 4
) (
  input  logic                   gclk,
  input  logic                   reset,
  input  logic                   core_reset_done,
  input  logic [4:0]             spc_pcx_req_pq,
  input  logic                   spc_pcx_atom_pq,
  input  logic [PCX_WIDTH-1:0]   spc_pcx_data_pa,
  output logic [4:0]             pcx_spc_grant_px,
  output logic                   max_pcx_valid,
  output logic [MAX_D_WIDTH-1:0] max_pcx_data,
  output logic                   max_pcx_sof,
  input  logic                   max_pcx_stall,
  input  logic                   max_cpx_empty,
  input  logic [MAX_D_WIDTH-1:0] max_cpx_data,
  input  logic                   max_cpx_sof,
  output logic                   max_cpx_read,
  output logic                   cpx_spc_data_rdy_cx2,
  output logic [CPX_WIDTH-1:0]   cpx_spc_data_cx2,
  output logic                   pcx_overflow,
  output logic                   cpx_resync
);

  localparam int unsigned PCX_FRAME = PCX_WIDTH + 6;
  localparam int unsigned PCX_BEATS = (PCX_FRAME + MAX_D_WIDTH - 1) / MAX_D_WIDTH;
  localparam int unsigned CPX_BEATS = (CPX_WIDTH + MAX_D_WIDTH - 1) / MAX_D_WIDTH;
  localparam int unsigned PCX_PAD   = PCX_BEATS * MAX_D_WIDTH;
  localparam int unsigned CPX_PAD   = CPX_BEATS * MAX_D_WIDTH;
  localparam int unsigned AW        = $clog2(PCX_DEPTH);
  localparam int unsigned BW        = $clog2(PCX_BEATS);
  localparam int unsigned CW        = $clog2(CPX_BEATS);

  // ---------------- PCX capture and buffer ----------------
  logic [4:0]         req_q;
  logic               atom_q;
  logic               wr_q;
  logic [PCX_PAD-1:0] mem [PCX_DEPTH];
  logic [AW-1:0]      head, tail;
  logic [AW:0]        count;
  logic [BW-1:0]      beat;
  logic [PCX_PAD-1:0] frame_c, head_entry;
  logic               full_c, push_c, pop_c, xfer_c, last_beat_c;

  assign frame_c     = PCX_PAD'({spc_pcx_atom_q_fix(atom_q), req_q, spc_pcx_data_pa});
  assign head_entry  = mem[head];
  assign full_c      = (count == (AW+1)'(PCX_DEPTH));
  assign push_c      = wr_q & ~full_c;
  assign last_beat_c = (beat == BW'(PCX_BEATS - 1));
  assign xfer_c      = max_pcx_valid & ~max_pcx_stall;
  assign pop_c       = xfer_c & last_beat_c;

  assign max_pcx_valid = (count != '0);
  assign max_pcx_sof   = max_pcx_valid & (beat == '0);
  assign max_pcx_data  = max_pcx_valid ? head_entry[32'(beat) * MAX_D_WIDTH +: MAX_D_WIDTH]
                                       : '0;

  // Identity helper keeps the frame concatenation readable.
  function automatic logic spc_pcx_atom_q_fix(input logic a);
    return a;
  endfunction

  // Request stage: latch req/atom so the frame is written with the next-cycle data.
  always_ff @(posedge gclk or posedge reset) begin
    if (reset) begin
      req_q  <= '0;
      atom_q <= 1'b0;
      wr_q   <= 1'b0;
    end else begin
      wr_q <= |spc_pcx_req_pq;
      if (|spc_pcx_req_pq) begin
        req_q  <= spc_pcx_req_pq;
        atom_q <= spc_pcx_atom_pq;
      end
    end
  end

  // Buffer storage; validity is tracked by the pointers and count.
  always_ff @(posedge gclk) begin
    if (push_c) mem[tail] <= frame_c;
  end

  // Pointers, occupancy, beat index, grant and overflow flag.
  always_ff @(posedge gclk or posedge reset) begin
    if (reset) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      beat             <= '0;
      pcx_spc_grant_px <= '0;
      pcx_overflow     <= 1'b0;
    end else begin
      if (push_c) tail <= tail + AW'(1);
      if (pop_c)  head <= head + AW'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
      if (xfer_c) beat <= last_beat_c ? '0 : beat + BW'(1);
      pcx_spc_grant_px <= pop_c ? head_entry[PCX_WIDTH +: 5] : 5'd0;
      if (wr_q & full_c) pcx_overflow <= 1'b1;
    end
  end

  // ---------------- CPX assembler ----------------
  logic [CPX_PAD-1:0] asm_q, asm_c;
  logic [CW-1:0]      cnt, slot_c;
  logic               pending, take_c, done_c, resync_set_c;

  // Read is held off for the cycle the packet is presented to the core.
  assign max_cpx_read         = ~reset & core_reset_done & ~max_cpx_empty & ~pending;
  assign cpx_spc_data_rdy_cx2 = pending;

`ifdef CCX2MAX_CPX_RESYNC_EN
  // sof realigns the assembler to slice 0; beats outside a frame are dropped.
  always_comb begin
    take_c       = max_cpx_read & (max_cpx_sof | (cnt != '0));
    slot_c       = max_cpx_sof ? '0 : cnt;
    resync_set_c = max_cpx_read & max_cpx_sof & (cnt != '0);
  end
`else
  logic unused_cpx_sof;
  assign unused_cpx_sof = max_cpx_sof;
  always_comb begin
    take_c       = max_cpx_read;
    slot_c       = cnt;
    resync_set_c = 1'b0;
  end
`endif

  assign done_c = take_c & (slot_c == CW'(CPX_BEATS - 1));

  // Assembly including the beat consumed this cycle.
  always_comb begin
    asm_c = asm_q;
    asm_c[32'(slot_c) * MAX_D_WIDTH +: MAX_D_WIDTH] = max_cpx_data;
  end

  always_ff @(posedge gclk or posedge reset) begin
    if (reset) begin
      asm_q            <= '0;
      cnt              <= '0;
      pending          <= 1'b0;
      cpx_spc_data_cx2 <= '0;
      cpx_resync       <= 1'b0;
    end else begin
      pending <= done_c;
      if (take_c) begin
        asm_q <= asm_c;
        cnt   <= done_c ? '0 : slot_c + CW'(1);
      end
      if (done_c) cpx_spc_data_cx2 <= asm_c[CPX_WIDTH-1:0];
      if (resync_set_c) cpx_resync <= 1'b1;
    end
  end

endmodule
